fsm_moore_timed: RTL and testbench

//  Parametrised Moore controller, IDLE/ST/HD/DT, with an integrated programmable hold timer.
//  The timer generates READY internally, so no external timer or READY handshake is needed.

---
 rtl/fsm_moore_timed.sv | 114 +++++++++++
 tb/tb_fsm_moore_timed.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fsm_moore_timed.sv
// Moore controller IDLE/ST/HD/DT with an internal hold timer, abort input,
// one-shot or auto-repeat re-arming and a saturating completion counter.
module fsm_moore_timed #(
  parameter int WIDTH     = 8,
  parameter bit MODE      = 1'b0,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 N_RESET,
  input  logic                 X,
  input  logic                 ABORT,
  input  logic [WIDTH-1:0]     DELAY,
  output logic                 RESET,
  output logic                 START,
  output logic                 BUSY,
  output logic                 Y,
  output logic [WIDTH-1:0]     COUNT,
  output logic [CNT_WIDTH-1:0] DONE_CNT
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ST   = 4'b0010,
    HD   = 4'b0100,
    DT   = 4'b1000
  } state_t;

  localparam logic [WIDTH-1:0]     CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] DONE_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] DONE_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_r;
  state_t               state_nxt_s;
  logic [WIDTH-1:0]     count_nxt_s;
  logic [CNT_WIDTH-1:0] done_nxt_s;

  // Output vector {RESET, START, BUSY, Y} for a given state.
  function automatic logic [3:0] decode_outputs(input state_t s);
    case (s)
      IDLE:    decode_outputs = 4'b1000;
      ST:      decode_outputs = 4'b0110;
      HD:      decode_outputs = 4'b0010;
      DT:      decode_outputs = 4'b0001;
      default: decode_outputs = 4'b1000;
    endcase
  endfunction

  // Next-state, hold-counter and completion-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = COUNT;
    done_nxt_s  = DONE_CNT;
    case (state_r)
      IDLE: begin
        if (X) begin
          state_nxt_s = ST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ST: begin
        state_nxt_s = HD;
        count_nxt_s = DELAY;
      end
      HD: begin
        // Abort takes priority over a hold that is just expiring.
        if (ABORT) begin
          state_nxt_s = IDLE;
          count_nxt_s = CNT_ZERO;
        end else if (COUNT == CNT_ZERO) begin
          state_nxt_s = DT;
          if (DONE_CNT != DONE_MAX) begin
            done_nxt_s = DONE_CNT + DONE_ONE;
          end else begin
            done_nxt_s = DONE_CNT;
          end
        end else begin
          count_nxt_s = COUNT - CNT_ONE;
        end
      end
      DT: begin
        if (!X) begin
          state_nxt_s = IDLE;
          count_nxt_s = CNT_ZERO;
        end else if (MODE) begin
          state_nxt_s = ST;
        end else begin
          state_nxt_s = DT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // State and registered Moore outputs, decoded from the next state.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_r                  <= IDLE;
      COUNT                    <= CNT_ZERO;
      DONE_CNT                 <= {CNT_WIDTH{1'b0}};
      {RESET, START, BUSY, Y}  <= 4'b1000;
    end else begin
      state_r                  <= state_nxt_s;
      COUNT                    <= count_nxt_s;
      DONE_CNT                 <= done_nxt_s;
      {RESET, START, BUSY, Y}  <= decode_outputs(state_nxt_s);
    end
  end

endmodule

// File: tb/tb_fsm_moore_timed.sv
// Scoreboard bench: two instances (one-shot and auto-repeat), WIDTH=4, CNT_WIDTH=2.
module tb_fsm_moore_timed;

  localparam logic [3:0] O_I = 4'b1000;
  localparam logic [3:0] O_S = 4'b0110;
  localparam logic [3:0] O_H = 4'b0010;
  localparam logic [3:0] O_D = 4'b0001;

  typedef struct {
    int         id;
    int         sel;
    logic [3:0] o;
    logic [3:0] cnt;
    logic [1:0] done;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       x_a = 1'b0, ab_a = 1'b0, x_b = 1'b0, ab_b = 1'b0;
  logic [3:0] d_a = 4'd0, d_b = 4'd0;
  logic       rst_a, start_a, busy_a, y_a, rst_b, start_b, busy_b, y_b;
  logic [3:0] cnt_a, cnt_b;
  logic [1:0] done_a, done_b;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   next_id = 0;

  always #5 clk = ~clk;

  fsm_moore_timed #(.WIDTH(4), .MODE(1'b0), .CNT_WIDTH(2)) dut_a (
    .CLK(clk), .N_RESET(n_reset), .X(x_a), .ABORT(ab_a), .DELAY(d_a),
    .RESET(rst_a), .START(start_a), .BUSY(busy_a), .Y(y_a),
    .COUNT(cnt_a), .DONE_CNT(done_a)
  );

  fsm_moore_timed #(.WIDTH(4), .MODE(1'b1), .CNT_WIDTH(2)) dut_b (
    .CLK(clk), .N_RESET(n_reset), .X(x_b), .ABORT(ab_b), .DELAY(d_b),
    .RESET(rst_b), .START(start_b), .BUSY(busy_b), .Y(y_b),
    .COUNT(cnt_b), .DONE_CNT(done_b)
  );

  // Monitor: one expectation per clock edge (or async reset), compared 1 time unit later.
  initial begin
    exp_t       e;
    logic [3:0] ao, ac;
    logic [1:0] ad;
    forever begin
      @(posedge clk or negedge n_reset);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ao = (e.sel == 0) ? {rst_a, start_a, busy_a, y_a} : {rst_b, start_b, busy_b, y_b};
        ac = (e.sel == 0) ? cnt_a : cnt_b;
        ad = (e.sel == 0) ? done_a : done_b;
        n_cmp++;
        if (ao !== e.o || ac !== e.cnt || ad !== e.done) begin
          n_err++;
          $display("FAIL chk#%0d dut%0d: got {RESET,START,BUSY,Y}=%b COUNT=%0d DONE_CNT=%0d, expected %b/%0d/%0d",
                   e.id, e.sel, ao, ac, ad, e.o, e.cnt, e.done);
        end
      end
    end
  end

  // Drive inputs for the coming cycle and record the outputs expected after its edge.
  task automatic step(input int sel, input logic x, input logic ab, input logic [3:0] d,
                      input logic [3:0] eo, input logic [3:0] ec, input logic [1:0] ed);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      x_a = x; ab_a = ab; d_a = d;
    end else begin
      x_b = x; ab_b = ab; d_b = d;
    end
    e.id = next_id; e.sel = sel; e.o = eo; e.cnt = ec; e.done = ed;
    next_id++;
    sb.push_back(e);
  endtask

  // One-shot transaction from IDLE; DELAY is scrambled after ST to show it is ignored.
  task automatic txn(input logic [3:0] dly, input int dt_extra,
                     input logic [1:0] db, input logic [1:0] da);
    logic xh;
    xh = (dt_extra > 0);
    step(0, 1'b1, 1'b0, dly, O_S, 4'd0, db);
    for (int i = int'(dly); i >= 0; i--)
      step(0, xh, 1'b0, (i == int'(dly)) ? dly : ~dly, O_H, 4'(i), db);
    step(0, xh, 1'b0, ~dly, O_D, 4'd0, da);
    for (int j = 0; j < dt_extra; j++)
      step(0, 1'b1, 1'b0, ~dly, O_D, 4'd0, da);
    step(0, 1'b0, 1'b0, dly, O_I, 4'd0, da);
  endtask

  // Abort applied while COUNT==at; ABORT is also high during ST, where it must be ignored.
  task automatic abrt(input logic [3:0] dly, input logic [3:0] at, input logic [1:0] dn);
    step(0, 1'b1, 1'b0, dly, O_S, 4'd0, dn);
    for (int i = int'(dly); i >= int'(at); i--)
      step(0, 1'b0, (i == int'(dly)), dly, O_H, 4'(i), dn);
    step(0, 1'b0, 1'b1, dly, O_I, 4'd0, dn);
    step(0, 1'b0, 1'b0, dly, O_I, 4'd0, dn);
  endtask

  initial begin
    // Reset state, then release.
    step(0, 1'b0, 1'b0, 4'd0, O_I, 4'd0, 2'd0);
    step(0, 1'b1, 1'b0, 4'd0, O_I, 4'd0, 2'd0);
    step(0, 1'b0, 1'b0, 4'd0, O_I, 4'd0, 2'd0);
    n_reset = 1'b1;
    step(0, 1'b0, 1'b0, 4'd0, O_I, 4'd0, 2'd0);

    txn(4'd3, 0, 2'd0, 2'd1);
    txn(4'd0, 0, 2'd1, 2'd2);
    txn(4'd15, 2, 2'd2, 2'd3);
    abrt(4'd5, 4'd2, 2'd3);
    abrt(4'd1, 4'd0, 2'd3);
    txn(4'd0, 0, 2'd3, 2'd3);
    txn(4'd0, 0, 2'd3, 2'd3);

    // Asynchronous reset in the middle of a hold, COUNT=5.
    step(0, 1'b1, 1'b0, 4'd7, O_S, 4'd0, 2'd3);
    step(0, 1'b0, 1'b0, 4'd7, O_H, 4'd7, 2'd3);
    step(0, 1'b0, 1'b0, 4'd7, O_H, 4'd6, 2'd3);
    step(0, 1'b0, 1'b0, 4'd7, O_H, 4'd5, 2'd3);
    @(posedge clk);
    #3;
    begin
      exp_t e;
      e.id = next_id; e.sel = 0; e.o = O_I; e.cnt = 4'd0; e.done = 2'd0;
      next_id++;
      sb.push_back(e);
    end
    n_reset = 1'b0;
    step(0, 1'b1, 1'b0, 4'd7, O_I, 4'd0, 2'd0);
    step(0, 1'b0, 1'b0, 4'd7, O_I, 4'd0, 2'd0);
    n_reset = 1'b1;
    step(0, 1'b0, 1'b0, 4'd7, O_I, 4'd0, 2'd0);

    // Auto-repeat: X held high, DELAY=2 gives a 5-cycle period.
    step(1, 1'b1, 1'b0, 4'd2, O_S, 4'd0, 2'd0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 2; i >= 0; i--)
        step(1, 1'b1, 1'b0, 4'd2, O_H, 4'(i), 2'(p));
      step(1, 1'b1, 1'b0, 4'd2, O_D, 4'd0, 2'(p + 1));
      if (p == 0)
        step(1, 1'b1, 1'b0, 4'd2, O_S, 4'd0, 2'd1);
    end
    step(1, 1'b0, 1'b0, 4'd2, O_I, 4'd0, 2'd2);

    @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
